game_round_timer: RTL and testbench
===================================

Name: game_round_timer

Overview:
- Consumes the one-cycle game-tick enable from the game clock stage and turns it into a countdown round timer in BCD seconds.
- Provides start/pause control, a per-second strobe, a gated game tick for downstream game logic, and a time-up flag.
- Sits between the game clock and the game FSM/score display: game clock pulse in, timer digits and time-up out to the HEX drivers and game control.

Parameters:
TICKS_PER_SEC, 12, game-tick pulses per displayed second; legal range 1..255.
START_TENS, 6, BCD tens digit loaded at round start; legal range 0..9.
START_ONES, 0, BCD ones digit loaded at round start; legal range 0..9. START_TENS and START_ONES must not both be 0.

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge.
resetn  input  1  asynchronous, active-low reset.
tick_pulse  input  1  one-CLOCK_50-cycle game-tick enable from the game clock.
start  input  1  level; sampled every cycle; starts or restarts a round.
pause  input  1  level; holds the countdown while high.
secs_tens  output  4  BCD tens digit of remaining seconds.
secs_ones  output  4  BCD ones digit of remaining seconds.
running  output  1  high while in RUN.
sec_strobe  output  1  one-cycle pulse per decremented second.
game_tick  output  1  tick_pulse gated by RUN.
time_up  output  1  high while in DONE.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; secs_tens=START_TENS; secs_ones=START_ONES; tick_cnt (8-bit)=0; running, sec_strobe, game_tick and time_up all 0.
- All outputs are registered. Every event below appears on the outputs on the first rising edge after the sampled input.
- FSM states: IDLE, RUN, PAUSE, DONE. running=(state==RUN); time_up=(state==DONE).
- IDLE:
  - start=1 -> RUN; reload digits from parameters; tick_cnt=0.
  - tick_pulse and pause are ignored.
- RUN:
  - On tick_pulse=1 with tick_cnt==TICKS_PER_SEC-1: tick_cnt=0; BCD-decrement the digits; sec_strobe=1 for exactly one cycle.
  - On tick_pulse=1 otherwise: tick_cnt+=1.
  - If a decrement produces 00 -> DONE in the same edge; sec_strobe still fires for that second.
  - pause=1 -> PAUSE. If tick_pulse and pause are both high in the same cycle, the tick is processed first and the state then becomes PAUSE (or DONE if the time expired; DONE has priority).
  - start=1 in RUN is ignored.
- PAUSE:
  - tick_pulse is ignored; tick_cnt and digits are held.
  - pause=0 -> RUN. start is ignored.
- DONE:
  - Digits are held at 00.
  - start=1 -> RUN with reload and tick_cnt=0. Without start, the block stays in DONE indefinitely.
- BCD decrement rules:
  - ones!=0: ones-=1.
  - ones==0: ones=9 and tens-=1.
  - Digits never leave 0..9 and never wrap below 00.
- game_tick: registered copy of (tick_pulse && state==RUN), evaluated with the pre-edge state. Latency is 1 cycle and the pulse is 1 cycle wide.
- start and pause are level-sensitive; no edge detection. start held high across DONE causes an immediate restart.
- Reset asserted mid-round: immediate return to the reset values above, with no strobe.
- TICKS_PER_SEC=1: every tick_pulse in RUN decrements one second.

Test Plan:
- Params TICKS_PER_SEC=2, START=0x03: release reset, pulse start one cycle, then 6 tick_pulses spaced 10 cycles apart -> digits 03->02->01->00 after ticks 2, 4 and 6; sec_strobe 3 single-cycle pulses; time_up=1 and running=0 from the edge after tick 6.
- Defaults (12, 0x60): start, then 12 ticks -> digits show 0x59 (tens 5, ones 9) and sec_strobe fires once; ticks 1-11 leave digits at 0x60.
- Pause: in RUN with tick_cnt=1 (TICKS_PER_SEC=2), assert pause with a simultaneous tick -> that tick decrements one second; 5 further ticks while paused cause no change and game_tick stays 0; deassert pause -> RUN resumes with tick_cnt=0.
- Gating: in IDLE, PAUSE and DONE, tick_pulse never produces game_tick. In RUN, each tick_pulse gives game_tick high exactly 1 cycle later, for 1 cycle.
- Restart and reset: assert start in DONE -> digits reload to 0x03 and running=1. Assert resetn=0 mid-RUN (asynchronously, between clock edges) -> outputs return immediately to their reset values (digits at START, state IDLE) without waiting for a clock edge.
- Ignored start: start held high through RUN -> no reload; the countdown continues normally.

Source files
------------

// File: rtl/game_round_timer.sv
// Countdown round timer in BCD seconds. Divides the game-tick enable into seconds, with
// start/pause control, a per-second strobe, a RUN-gated game tick and a time-up flag.
module game_round_timer #(
    parameter int unsigned TICKS_PER_SEC = 12,  // 1..255
    parameter int unsigned START_TENS    = 6,   // 0..9
    parameter int unsigned START_ONES    = 0    // 0..9, not both zero
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       tick_pulse,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       running,
    output logic       sec_strobe,
    output logic       game_tick,
    output logic       time_up
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_SEC - 1);
    localparam logic [3:0] LOAD_TENS = 4'(START_TENS);
    localparam logic [3:0] LOAD_ONES = 4'(START_ONES);

    state_t     state;
    logic [7:0] tick_cnt;
    logic [3:0] dec_tens;
    logic [3:0] dec_ones;
    logic       dec_zero;
    logic       sec_done;

    // NOTE: defaults come first so that every path assigns every signal and no latch is inferred.
    always_comb begin
        dec_tens = secs_tens;
        dec_ones = secs_ones;
        if (secs_ones != 4'd0) begin
            dec_ones = secs_ones - 4'd1;
        end else if (secs_tens != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = secs_tens - 4'd1;
        end
        dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
        sec_done = tick_pulse && (tick_cnt == TICK_LAST);
    end

    // NOTE: state registers use non-blocking assignments, so every branch below reads pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            secs_tens  <= LOAD_TENS;
            secs_ones  <= LOAD_ONES;
            tick_cnt   <= 8'd0;
            running    <= 1'b0;
            sec_strobe <= 1'b0;
            game_tick  <= 1'b0;
            time_up    <= 1'b0;
        end else begin
            game_tick  <= tick_pulse && (state == RUN);
            sec_strobe <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        time_up   <= 1'b0;
                        secs_tens <= LOAD_TENS;
                        secs_ones <= LOAD_ONES;
                        tick_cnt  <= 8'd0;
                    end
                end
                RUN: begin
                    if (sec_done) begin
                        tick_cnt   <= 8'd0;
                        secs_tens  <= dec_tens;
                        secs_ones  <= dec_ones;
                        sec_strobe <= 1'b1;
                    end else if (tick_pulse) begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                    // An expiring second wins over a simultaneous pause request.
                    if (sec_done && dec_zero) begin
                        state   <= DONE;
                        running <= 1'b0;
                        time_up <= 1'b1;
                    end else if (pause) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    time_up <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_timer.sv
// Bench for game_round_timer: two instances (TICKS_PER_SEC=2/START=03 and defaults) share
// stimulus and are checked against an integer-seconds reference model of the round.
module tb_game_round_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn = 1'b0;
    logic       tick_pulse = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic       a_running, a_strobe, a_gtick, a_time_up;
    logic       b_running, b_strobe, b_gtick, b_time_up;

    game_round_timer #(.TICKS_PER_SEC(2), .START_TENS(0), .START_ONES(3)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .tick_pulse(tick_pulse), .start(start), .pause(pause),
        .secs_tens(a_tens), .secs_ones(a_ones), .running(a_running), .sec_strobe(a_strobe),
        .game_tick(a_gtick), .time_up(a_time_up)
    );

    game_round_timer dut_b (
        .CLOCK_50(clk), .resetn(resetn), .tick_pulse(tick_pulse), .start(start), .pause(pause),
        .secs_tens(b_tens), .secs_ones(b_ones), .running(b_running), .sec_strobe(b_strobe),
        .game_tick(b_gtick), .time_up(b_time_up)
    );

    int total = 0;
    int bad = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE = 3;

    int tps[2] = '{2, 12};
    int load_secs[2] = '{3, 60};
    int m_secs[2];
    int m_cnt[2];
    int m_mode[2];
    bit m_strobe[2];
    bit m_gtick[2];

    function automatic logic [11:0] actual(int i);
        if (i == 0) return {a_tens, a_ones, a_running, a_strobe, a_gtick, a_time_up};
        return {b_tens, b_ones, b_running, b_strobe, b_gtick, b_time_up};
    endfunction

    function automatic logic [11:0] expected(int i);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(m_secs[i] / 10);
        o = 4'(m_secs[i] % 10);
        return {t, o, m_mode[i] == M_RUN, m_strobe[i], m_gtick[i], m_mode[i] == M_DONE};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = load_secs[i];
            m_cnt[i] = 0;
            m_mode[i] = M_IDLE;
            m_strobe[i] = 1'b0;
            m_gtick[i] = 1'b0;
        end
    endfunction

    // One round-timer edge in terms of whole seconds and elapsed ticks.
    function automatic void model_edge(bit st, bit ps, bit tk);
        for (int i = 0; i < 2; i++) begin
            m_strobe[i] = 1'b0;
            m_gtick[i] = tk && (m_mode[i] == M_RUN);
            case (m_mode[i])
                M_IDLE, M_DONE: if (st) begin
                    m_mode[i] = M_RUN;
                    m_secs[i] = load_secs[i];
                    m_cnt[i] = 0;
                end
                M_RUN: begin
                    if (tk) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == tps[i]) begin
                            m_cnt[i] = 0;
                            m_secs[i]--;
                            m_strobe[i] = 1'b1;
                        end
                    end
                    if (m_secs[i] == 0) m_mode[i] = M_DONE;
                    else if (ps) m_mode[i] = M_PAUSE;
                end
                default: if (!ps) m_mode[i] = M_RUN;
            endcase
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_edge(start, pause, tick_pulse);
        #1;
    endtask

    task automatic apply_reset();
        start = 1'b0;
        pause = 1'b0;
        tick_pulse = 1'b0;
        resetn = 1'b0;
        model_reset();
        step();
        step();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (actual(i) !== expected(i)) begin
                bad++;
                $display("FAIL reset dut%0d got=%h want=%h", i, actual(i), expected(i));
            end
        end
        total++;
        if ({a_tens, a_ones, b_tens, b_ones} !== 16'h0360) begin
            bad++;
            $display("FAIL reset_digits got=%h want=0360", {a_tens, a_ones, b_tens, b_ones});
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_countdown();
        int strobes = 0;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            for (int c = 0; c < 10; c++) begin
                tick_pulse = (c == 0);
                step();
                tick_pulse = 1'b0;
                strobes += int'(a_strobe);
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (actual(i) !== expected(i)) begin
                        bad++;
                        $display("FAIL countdown dut%0d tick=%0d cyc=%0d got=%h want=%h",
                                 i, k, c, actual(i), expected(i));
                    end
                end
            end
            if (k % 2 == 0) begin
                total++;
                if ({a_tens, a_ones} !== 8'(3 - k / 2)) begin
                    bad++;
                    $display("FAIL countdown_digits tick=%0d got=%h want=%0d", k, {a_tens, a_ones}, 3 - k / 2);
                end
            end
        end
        total++;
        if (strobes != 3 || a_time_up !== 1'b1 || a_running !== 1'b0) begin
            bad++;
            $display("FAIL countdown_end strobes=%0d time_up=%b running=%b want 3/1/0", strobes, a_time_up, a_running);
        end
    endtask

    task automatic test_default();
        int strobes = 0;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            for (int c = 0; c < 3; c++) begin
                tick_pulse = (c == 0);
                step();
                tick_pulse = 1'b0;
                strobes += int'(b_strobe);
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (actual(i) !== expected(i)) begin
                        bad++;
                        $display("FAIL default dut%0d tick=%0d got=%h want=%h", i, k, actual(i), expected(i));
                    end
                end
            end
            total++;
            if ({b_tens, b_ones} !== ((k < 12) ? 8'h60 : 8'h59)) begin
                bad++;
                $display("FAIL default_digits tick=%0d got=%h", k, {b_tens, b_ones});
            end
        end
        total++;
        if (strobes != 1) begin
            bad++;
            $display("FAIL default_strobes got=%0d want=1", strobes);
        end
    endtask

    task automatic test_pause();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        tick_pulse = 1'b1;
        step();
        pause = 1'b1;
        step();
        tick_pulse = 1'b0;
        total++;
        if ({a_tens, a_ones, a_running, a_time_up} !== 10'b0000_0010_00) begin
            bad++;
            $display("FAIL pause_enter got=%h/%b/%b want=02/0/0", {a_tens, a_ones}, a_running, a_time_up);
        end
        for (int k = 0; k < 10; k++) begin
            tick_pulse = (k % 2 == 0);
            step();
            tick_pulse = 1'b0;
            total++;
            if (a_gtick !== 1'b0 || {a_tens, a_ones} !== 8'h02 || actual(1) !== expected(1)) begin
                bad++;
                $display("FAIL pause_hold cyc=%0d gtick=%b digits=%h b=%h want 0/02/%h",
                         k, a_gtick, {a_tens, a_ones}, actual(1), expected(1));
            end
        end
        pause = 1'b0;
        step();
        total++;
        if (a_running !== 1'b1) begin
            bad++;
            $display("FAIL pause_resume running=%b want=1", a_running);
        end
        for (int k = 1; k <= 2; k++) begin
            tick_pulse = 1'b1;
            step();
            tick_pulse = 1'b0;
            total++;
            if ({a_tens, a_ones} !== ((k == 1) ? 8'h02 : 8'h01) || actual(0) !== expected(0)) begin
                bad++;
                $display("FAIL pause_after tick=%0d got=%h want=%h", k, actual(0), expected(0));
            end
        end
    endtask

    task automatic test_gating();
        apply_reset();
        tick_pulse = 1'b1;
        step();
        tick_pulse = 1'b0;
        step();
        total++;
        if (a_gtick !== 1'b0 || b_gtick !== 1'b0) begin
            bad++;
            $display("FAIL gate_idle got=%b%b want=00", a_gtick, b_gtick);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick_pulse = 1'b1;
            step();
            tick_pulse = 1'b0;
            total++;
            if (a_gtick !== 1'b1 || actual(0) !== expected(0)) begin
                bad++;
                $display("FAIL gate_run_hi tick=%0d got=%h want=%h", k, actual(0), expected(0));
            end
            step();
            total++;
            if (a_gtick !== 1'b0 || actual(1) !== expected(1)) begin
                bad++;
                $display("FAIL gate_run_lo tick=%0d gtick=%b b=%h want 0/%h", k, a_gtick, actual(1), expected(1));
            end
        end
        tick_pulse = 1'b1;
        step();
        tick_pulse = 1'b0;
        total++;
        if (a_time_up !== 1'b1 || a_gtick !== 1'b0) begin
            bad++;
            $display("FAIL gate_done time_up=%b gtick=%b want=1/0", a_time_up, a_gtick);
        end
    endtask

    task automatic test_restart_hold();
        start = 1'b1;
        step();
        total++;
        if ({a_tens, a_ones} !== 8'h03 || a_running !== 1'b1 || a_time_up !== 1'b0) begin
            bad++;
            $display("FAIL restart got=%h/%b/%b want=03/1/0", {a_tens, a_ones}, a_running, a_time_up);
        end
        for (int c = 0; c < 24; c++) begin
            tick_pulse = (c % 3 == 0);
            step();
            tick_pulse = 1'b0;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (actual(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL start_held dut%0d cyc=%0d got=%h want=%h", i, c, actual(i), expected(i));
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_pulse = 1'b1;
            step();
            tick_pulse = 1'b0;
        end
        @(posedge clk);
        model_edge(start, pause, tick_pulse);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (actual(i) !== expected(i)) begin
                bad++;
                $display("FAIL async_reset dut%0d got=%h want=%h", i, actual(i), expected(i));
            end
        end
        total++;
        if ({a_tens, a_ones, a_running} !== 9'b0000_0011_0) begin
            bad++;
            $display("FAIL async_reset_a got=%h running=%b want=03/0", {a_tens, a_ones}, a_running);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 7) == 0);
            tick_pulse = ($urandom_range(0, 2) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (actual(i) !== expected(i)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc=%0d got=%h want=%h", i, c, actual(i), expected(i));
                end
            end
        end
        start = 1'b0;
        pause = 1'b0;
        tick_pulse = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_default();
        test_pause();
        test_gating();
        test_restart_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
